lcd1602_bus_driver: RTL and testbench



---
 rtl/lcd1602_pkg.sv | 29 ++
 rtl/lcd1602_delay_cnt.sv | 26 ++
 rtl/lcd1602_bus_driver.sv | 160 ++++++++++++++++
 tb/tb_lcd1602_bus_driver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd1602_pkg.sv
// Shared types, instruction constants and cycle-count helpers for the LCD1602 controller.
package lcd1602_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_NIBBLE_GAP,
    ST_EXEC_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  // A zero-length delay still occupies one cycle.
  function automatic int unsigned at_least_one(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned clk_mhz);
    return at_least_one(us * clk_mhz);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd1602_delay_cnt.sv
// Loadable saturating down-counter; done_c is high while the count sits at zero.
module lcd1602_delay_cnt #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/lcd1602_bus_driver.sv
// HD44780 write-cycle generator: byte handshake in, RS/E/DB pin timing out.
// Define LCD1602_4BIT_MODE_EN for a 4-bit bus (two nibble cycles per byte).
module lcd1602_bus_driver
  import lcd1602_pkg::*;
#(
  parameter int unsigned CLK_MHZ    = 50,
  parameter int unsigned SETUP_CYC  = 3,
  parameter int unsigned E_HIGH_CYC = 12,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned EXEC_US    = 40,
  parameter int unsigned CLEAR_US   = 1600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid_i,
  input  logic       cmd_rs_i,
  input  logic [7:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic       busy_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned SETUP_N = at_least_one(SETUP_CYC);
  localparam int unsigned EHIGH_N = at_least_one(E_HIGH_CYC);
  localparam int unsigned HOLD_N  = at_least_one(HOLD_CYC);
  localparam int unsigned EXEC_N  = us_to_cyc(EXEC_US, CLK_MHZ);
  localparam int unsigned CLEAR_N = us_to_cyc(CLEAR_US, CLK_MHZ);
  localparam int unsigned MAX_N   = max2(max2(max2(SETUP_N, EHIGH_N), max2(HOLD_N, EXEC_N)),
                                         max2(CLEAR_N, us_to_cyc(1, CLK_MHZ)));
  localparam int unsigned CNT_W   = $clog2(MAX_N + 1);
`ifdef LCD1602_4BIT_MODE_EN
  localparam int unsigned GAP_N   = us_to_cyc(1, CLK_MHZ);
`endif

  lcd_state_e       state_q, state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_done_c;
  logic             accept_c;
  logic             long_wait_c;
  logic [7:0]       lat_data;
`ifdef LCD1602_4BIT_MODE_EN
  logic             nib_lo_q;
`endif

  lcd1602_delay_cnt #(.CNT_W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done_c   (cnt_done_c)
  );

  // Clear Display and Return Home (0x01..0x03) need the long execution wait.
  assign long_wait_c = !lcd_rs_o && ((lat_data == LCD_CLEAR) || (lat_data[7:1] == LCD_HOME[7:1]));
  assign lcd_rw_o    = 1'b0;

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          accept_c = 1'b1;
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SETUP_N - 1);
        end
      end
      ST_SETUP: begin
        if (cnt_done_c) begin
          state_d  = ST_E_HIGH;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(EHIGH_N - 1);
        end
      end
      ST_E_HIGH: begin
        if (cnt_done_c) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(HOLD_N - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_done_c) begin
`ifdef LCD1602_4BIT_MODE_EN
          if (!nib_lo_q) begin
            state_d  = ST_NIBBLE_GAP;
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(GAP_N - 1);
          end else
`endif
          begin
            state_d  = ST_EXEC_WAIT;
            cnt_load = 1'b1;
            cnt_val  = long_wait_c ? CNT_W'(CLEAR_N - 1) : CNT_W'(EXEC_N - 1);
          end
        end
      end
`ifdef LCD1602_4BIT_MODE_EN
      ST_NIBBLE_GAP: begin
        if (cnt_done_c) begin
          state_d  = ST_SETUP;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SETUP_N - 1);
        end
      end
`endif
      ST_EXEC_WAIT: begin
        if (cnt_done_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they change with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      lcd_e_o     <= 1'b0;
      lcd_rs_o    <= 1'b0;
      lcd_data_o  <= 8'h00;
      lat_data    <= 8'h00;
`ifdef LCD1602_4BIT_MODE_EN
      nib_lo_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_o <= (state_d == ST_IDLE);
      busy_o      <= (state_d != ST_IDLE);
      lcd_e_o     <= (state_d == ST_E_HIGH);
      if (accept_c) begin
        lcd_rs_o <= cmd_rs_i;
        lat_data <= cmd_data_i;
`ifdef LCD1602_4BIT_MODE_EN
        lcd_data_o <= {cmd_data_i[7:4], 4'h0};
        nib_lo_q   <= 1'b0;
`else
        lcd_data_o <= cmd_data_i;
`endif
      end
`ifdef LCD1602_4BIT_MODE_EN
      else if ((state_q == ST_NIBBLE_GAP) && cnt_done_c) begin
        lcd_data_o <= {lat_data[3:0], 4'h0};
        nib_lo_q   <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_driver.sv
// Scoreboard bench for lcd1602_bus_driver: expected pulses/latencies queued at accept, checked by a pin monitor.
module tb_lcd1602_bus_driver;

  localparam int unsigned TB_MHZ     = 5;
  localparam int unsigned SETUP      = 3;
  localparam int unsigned EHIGH      = 12;
  localparam int unsigned HOLD       = 2;
  localparam int unsigned SHORT_WAIT = 40 * TB_MHZ;
  localparam int unsigned LONG_WAIT  = 1600 * TB_MHZ;
  localparam int unsigned GAP        = TB_MHZ;
`ifdef LCD1602_4BIT_MODE_EN
  localparam int unsigned PULSES_PER_BYTE = 2;
`else
  localparam int unsigned PULSES_PER_BYTE = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_rs_i = 1'b0;
  logic [7:0] cmd_data_i = 8'h00;
  logic       cmd_ready_o, busy_o, lcd_rs_o, lcd_rw_o, lcd_e_o;
  logic [7:0] lcd_data_o;

  always #5 clk = ~clk;

  lcd1602_bus_driver #(
    .CLK_MHZ(TB_MHZ), .SETUP_CYC(SETUP), .E_HIGH_CYC(EHIGH),
    .HOLD_CYC(HOLD), .EXEC_US(40), .CLEAR_US(1600)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_rs_i(cmd_rs_i), .cmd_data_i(cmd_data_i),
    .cmd_ready_o(cmd_ready_o), .busy_o(busy_o),
    .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o), .lcd_e_o(lcd_e_o), .lcd_data_o(lcd_data_o)
  );

  typedef struct packed { logic rs; logic [7:0] bus; } pulse_t;

  pulse_t      exp_pulse_q[$];
  int unsigned exp_lat_q[$];
  logic [8:0]  stim_q[$];
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit is_long(input logic rs, input logic [7:0] b);
    return !rs && (b == 8'h01 || b == 8'h02 || b == 8'h03);
  endfunction

  // Reference: each byte costs its pulse phases plus the execution wait its value selects.
  task automatic push_expect(input logic rs, input logic [7:0] b);
    int unsigned w;
    w = is_long(rs, b) ? LONG_WAIT : SHORT_WAIT;
`ifdef LCD1602_4BIT_MODE_EN
    exp_pulse_q.push_back({rs, b[7:4], 4'h0});
    exp_pulse_q.push_back({rs, b[3:0], 4'h0});
    exp_lat_q.push_back(2 * (SETUP + EHIGH + HOLD) + GAP + w);
`else
    exp_pulse_q.push_back({rs, b});
    exp_lat_q.push_back(SETUP + EHIGH + HOLD + w);
`endif
  endtask

  // Pin monitor
  logic        mon_en = 1'b0;
  logic        e_prev = 1'b0;
  logic        ready_prev = 1'b1;
  logic [8:0]  bus_prev = 9'h0;
  int unsigned stable = 0, e_len = 0, hold_left = 0, busy_len = 0;
  int          e_rises = 0;
  logic        hold_bad = 1'b0;
  pulse_t      cur = '0;

  always @(negedge clk) begin
    logic [8:0] bus_now;
    int unsigned lat;
    bus_now = {lcd_rs_o, lcd_data_o};
    if (bus_now != bus_prev) stable = 0;
    else stable++;
    if (lcd_e_o && !e_prev) e_rises++;
    if (mon_en) begin
      if (lcd_e_o && !e_prev) begin
        check("setup_stable", 32'(stable >= SETUP), 1);
        check("rw_low", 32'(lcd_rw_o), 0);
        if (exp_pulse_q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          cur = exp_pulse_q.pop_front();
          check("pulse_rs", 32'(lcd_rs_o), 32'(cur.rs));
          check("pulse_bus", 32'(lcd_data_o), 32'(cur.bus));
        end
        e_len = 1;
      end else if (lcd_e_o) begin
        e_len++;
      end else if (e_prev) begin
        check("e_width", e_len, EHIGH);
        hold_left = HOLD;
        hold_bad  = 1'b0;
      end
      if (!lcd_e_o && hold_left > 0) begin
        if (bus_now != cur) hold_bad = 1'b1;
        hold_left--;
        if (hold_left == 0) check("hold_bus", 32'(hold_bad), 0);
      end
      if (!cmd_ready_o) busy_len++;
      if (cmd_ready_o != ready_prev) check("busy_vs_ready", 32'(busy_o), 32'(!cmd_ready_o));
      if (cmd_ready_o && !ready_prev) begin
        if (exp_lat_q.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          lat = exp_lat_q.pop_front();
          check("ready_latency", busy_len, lat);
        end
        busy_len = 0;
      end
    end
    e_prev     = lcd_e_o;
    ready_prev = cmd_ready_o;
    bus_prev   = bus_now;
  end

  // Presents queued bytes when ready; scribbles the inputs while the driver is busy.
  task automatic run_stream();
    int unsigned guard, limit;
    logic [8:0] item;
    guard = 0;
    limit = (stim_q.size() + 1) * (LONG_WAIT + 200);
    while (stim_q.size() > 0 && guard < limit) begin
      @(negedge clk);
      guard++;
      if (cmd_ready_o) begin
        item = stim_q.pop_front();
        cmd_valid_i = 1'b1;
        cmd_rs_i    = item[8];
        cmd_data_i  = item[7:0];
        push_expect(item[8], item[7:0]);
      end else begin
        cmd_valid_i = 1'b1;
        cmd_rs_i    = 1'($urandom);
        cmd_data_i  = 8'($urandom);
      end
    end
    check("stream_timeout", 32'(guard < limit), 1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((exp_lat_q.size() != 0 || exp_pulse_q.size() != 0) && n < LONG_WAIT + 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", 32'(n < LONG_WAIT + 500), 1);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rises0, nlong, n;
    logic rs;
    logic [7:0] b;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready_o), 1);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_e", 32'(lcd_e_o), 0);
    check("rst_rs", 32'(lcd_rs_o), 0);
    check("rst_rw", 32'(lcd_rw_o), 0);
    check("rst_data", 32'(lcd_data_o), 0);
    mon_en = 1'b1;

    // Directed bytes: data 'A', clear/home variants, function set, no-op
    stim_q = '{9'h141, 9'h001, 9'h038, 9'h000, 9'h002, 9'h003};
    run_stream();
    drain();

    // CGRAM address then eight glyph rows
    rises0 = e_rises;
    stim_q.push_back(9'h040);
    for (int i = 0; i < 8; i++) stim_q.push_back({1'b1, 8'($urandom_range(0, 31))});
    run_stream();
    drain();
    check("cgram_pulses", 32'(e_rises - rises0), 9 * PULSES_PER_BYTE);

    // Random bytes, biased toward the short/long boundary, with few long waits
    nlong = 0;
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      if (is_long(rs, b)) begin
        if (nlong >= 2) rs = 1'b1;
        else nlong++;
      end
      stim_q.push_back({rs, b});
    end
    run_stream();
    drain();

    // Reset while E is high: E drops immediately and the byte is dropped
    mon_en = 1'b0;
    stim_q.push_back(9'h155);
    run_stream();
    n = 0;
    while (!lcd_e_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("e_seen_before_reset", 32'(lcd_e_o), 1);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_e", 32'(lcd_e_o), 0);
    check("async_rst_ready", 32'(cmd_ready_o), 1);
    exp_pulse_q.delete();
    exp_lat_q.delete();
    rises0 = e_rises;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    check("discarded_no_pulse", 32'(e_rises - rises0), 0);
    check("post_rst_ready", 32'(cmd_ready_o), 1);
    check("post_rst_data", 32'(lcd_data_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
